// File: rtl/mlaccel_qpi_pkg.sv
// Shared constants and helpers for the QPI host link.
package mlaccel_qpi_pkg;

  localparam logic [3:0] IDLE_DO = 4'hF;

  function automatic bit lanes_legal(input int lanes);
    return (lanes == 1) || (lanes == 2) || (lanes == 4);
  endfunction

  function automatic int beats_of(input int lanes);
    return 8 / lanes;
  endfunction

endpackage

// File: rtl/mlaccel_sync_fifo.sv
// Single-clock FIFO with show-ahead read data and extra-bit wrapping pointers.
module mlaccel_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  // A full FIFO may still take a push when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mlaccel_qpi_link.sv
// Host-link slave: oversampled 1/2/4-lane byte serdes with TX FIFO, back-pressure and sticky error.
module mlaccel_qpi_link
  import mlaccel_qpi_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TX_DEPTH    = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        qpi_csb_di,
  input  logic                        qpi_clk_di,
  input  logic [LANES-1:0]            qpi_io_di,
  output logic [LANES-1:0]            qpi_io_do,
  output logic [LANES-1:0]            qpi_io_oe,
  output logic                        qpi_rdy_do,
  output logic                        qpi_err_do,
  output logic                        din_valid,
  input  logic                        din_ready,
  output logic                        din_start,
  output logic [7:0]                  din_data,
  input  logic                        dout_valid,
  output logic                        dout_ready,
  input  logic [7:0]                  dout_data,
  output logic [$clog2(TX_DEPTH):0]   tx_level
);
  localparam int BEATS = beats_of(LANES);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LW    = $clog2(TX_DEPTH) + 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  if (!lanes_legal(LANES) || SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_param_check
    $error("mlaccel_qpi_link: illegal LANES or SYNC_STAGES");
  end

  logic [SYNC_STAGES-1:0]            csb_sync_q, csb_sync_d;
  logic [SYNC_STAGES-1:0]            clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0][LANES-1:0] io_sync_q, io_sync_d;
  logic                              clk_dly_q, clk_dly_d;
  logic                              csb_s, clk_s, rise, fall;
  logic [LANES-1:0]                  io_s;

  logic             latched_q, latched_d;
  logic [BW-1:0]    rx_beat_q, rx_beat_d, tx_beat_q, tx_beat_d;
  logic [7:0]       rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d, rx_next;
  logic             din_valid_q, din_valid_d, din_start_q, din_start_d;
  logic [7:0]       din_data_q, din_data_d;
  logic             first_byte_q, first_byte_d, err_q, err_d, oe_q, oe_d, rdy_q, rdy_d;
  logic [LANES-1:0] do_q, do_d;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_rdata;
  logic [LW-1:0]    fifo_level;

  assign csb_s = csb_sync_q[SYNC_STAGES-1];
  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign io_s  = io_sync_q[SYNC_STAGES-1];
  assign rise  = clk_s && !clk_dly_q;
  assign fall  = !clk_s && clk_dly_q;

  assign fifo_push = dout_valid && dout_ready;
  assign fifo_pop  = !latched_q && !csb_s && fall && (tx_beat_q == '0) && !fifo_empty;

  mlaccel_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .wdata (dout_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    csb_sync_d   = {csb_sync_q[SYNC_STAGES-2:0], qpi_csb_di};
    clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], qpi_clk_di};
    io_sync_d    = {io_sync_q[SYNC_STAGES-2:0], qpi_io_di};
    clk_dly_d    = clk_s;
    rx_next      = {rx_shift_q[7-LANES:0], io_s};
    latched_d    = latched_q;
    rx_beat_d    = rx_beat_q;
    tx_beat_d    = tx_beat_q;
    rx_shift_d   = rx_shift_q;
    tx_shift_d   = tx_shift_q;
    din_valid_d  = 1'b0;
    din_start_d  = din_start_q;
    din_data_d   = din_data_q;
    first_byte_d = first_byte_q;
    err_d        = err_q;
    oe_d         = oe_q;
    do_d         = do_q;
    rdy_d        = (fifo_level != '0);

    if (latched_q) begin
      // Held idle after reset until the host is seen deselected.
      rx_beat_d    = '0;
      tx_beat_d    = '0;
      oe_d         = 1'b0;
      first_byte_d = 1'b1;
      latched_d    = !csb_s;
    end else if (csb_s) begin
      rx_beat_d    = '0;
      tx_beat_d    = '0;
      first_byte_d = 1'b1;
      err_d        = 1'b0;
      oe_d         = 1'b0;
      do_d         = IDLE_DO[LANES-1:0];
    end else begin
      if (din_valid_q && !din_ready) err_d = 1'b1;

      if (rise) begin
        rx_shift_d = rx_next;
        if (rx_beat_q == LAST_BEAT) begin
          rx_beat_d    = '0;
          din_valid_d  = 1'b1;
          din_data_d   = rx_next;
          din_start_d  = first_byte_q;
          first_byte_d = 1'b0;
        end else begin
          rx_beat_d = rx_beat_q + BW'(1);
        end
      end

      if (fall) begin
        tx_beat_d = (tx_beat_q == LAST_BEAT) ? '0 : tx_beat_q + BW'(1);
        if (tx_beat_q == '0) begin
          if (!fifo_empty) begin
            oe_d       = 1'b1;
            do_d       = fifo_rdata[7 -: LANES];
            tx_shift_d = {fifo_rdata[7-LANES:0], {LANES{1'b0}}};
          end else begin
            oe_d = 1'b0;
            do_d = IDLE_DO[LANES-1:0];
          end
        end else if (oe_q) begin
          do_d       = tx_shift_q[7 -: LANES];
          tx_shift_d = {tx_shift_q[7-LANES:0], {LANES{1'b0}}};
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    csb_sync_q <= csb_sync_d;
    clk_sync_q <= clk_sync_d;
    io_sync_q  <= io_sync_d;
    clk_dly_q  <= clk_dly_d;
    rx_shift_q <= rx_shift_d;
    tx_shift_q <= tx_shift_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      latched_q    <= 1'b1;
      rx_beat_q    <= '0;
      tx_beat_q    <= '0;
      din_valid_q  <= 1'b0;
      din_start_q  <= 1'b0;
      din_data_q   <= '0;
      first_byte_q <= 1'b1;
      err_q        <= 1'b0;
      oe_q         <= 1'b0;
      do_q         <= '0;
      rdy_q        <= 1'b0;
    end else begin
      latched_q    <= latched_d;
      rx_beat_q    <= rx_beat_d;
      tx_beat_q    <= tx_beat_d;
      din_valid_q  <= din_valid_d;
      din_start_q  <= din_start_d;
      din_data_q   <= din_data_d;
      first_byte_q <= first_byte_d;
      err_q        <= err_d;
      oe_q         <= oe_d;
      do_q         <= do_d;
      rdy_q        <= rdy_d;
    end
  end

  assign qpi_io_do  = do_q;
  assign qpi_io_oe  = {LANES{oe_q}};
  assign qpi_rdy_do = rdy_q;
  assign qpi_err_do = err_q;
  assign din_valid  = din_valid_q;
  assign din_start  = din_start_q;
  assign din_data   = din_data_q;
  assign dout_ready = !fifo_full;
  assign tx_level   = fifo_level;

endmodule
